fetch: RTL and testbench

//   Instruction fetch stage: producer of the ir/pc stream consumed by decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch.sv | 145 ++++++++++++++
 tb/tb_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: PC and instruction word types,
// the canonical NOP encoding, and the {pc, instr} entry held in the fetch buffer.
// No ports; imported by fetch and fetch_fifo.
package fetch_pkg;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] word_t;

  // addi x0, x0, 0
  localparam word_t NOP = 32'h0000_0013;

  typedef struct packed {
    pc_t   pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: synchronous FIFO of fetch_entry_t between imem responses and decode.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: push on full is ignored unless a pop happens the same cycle; flush dominates push.
// Ports: clk, reset (sync, active-high), push/push_data, pop, flush, head, count, empty, full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch.sv
// Purpose: fetch stage; owns the PC, issues in-order imem requests, buffers responses for decode.
// Latency: ir/ir_pc/ir_valid are registered, one cycle after the imem response (FIFO bypass).
// Backpressure: stall holds outputs; requests stop once outstanding + buffered reaches FIFO_DEPTH.
// Ports: clk, reset (sync, active-high), stall, redirect/redirect_pc, imem_req/imem_addr/imem_ready,
//   imem_rvalid/imem_rdata, ir/ir_pc/ir_valid; fetch_misaligned only when FETCH_MISALIGN_EN is defined.
// FETCH_MISALIGN_EN: a misaligned redirect target pulses fetch_misaligned and halts fetching until
//   the next redirect or reset; when undefined the low two target bits are cleared instead.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int             CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]    CAP = (CW + 1)'(FIFO_DEPTH);

  pc_t          pc;
  pc_t          resp_pc;      // PC of the next response that will be kept
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;     // responses still owed from before the last redirect
  logic [CW-1:0] out_next;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty;
  logic         fifo_full;
  fetch_entry_t fifo_head;
  fetch_entry_t rsp_entry;
  pc_t          target;
  logic         halt;
  logic         accept;
  logic         rsp;
  logic         keep;
  logic         drop;
  logic         bypass;
  logic         pop;
  logic         push;

`ifdef FETCH_MISALIGN_EN
  logic halted;
  assign target = redirect_pc;
  assign halt   = halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      halted           <= 1'b0;
      fetch_misaligned <= 1'b0;
    end else begin
      fetch_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) halted <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign target = redirect_pc & ~32'h3;
  assign halt   = 1'b0;
`endif

  assign imem_req  = !reset && !redirect && !halt &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < CAP);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Responses only count against real outstanding requests; anything else is stray.
  assign rsp      = imem_rvalid && (outstanding != '0);
  assign keep     = rsp && (discard == '0);
  assign drop     = rsp && (discard != '0);
  assign out_next = outstanding + CW'(accept) - CW'(rsp);

  // A kept response arriving while the buffer is empty goes straight to the output register.
  assign bypass    = !redirect && !stall && fifo_empty && keep;
  assign pop       = !redirect && !stall && !fifo_empty;
  assign push      = keep && !bypass && (!fifo_full || pop);
  assign rsp_entry = '{pc: resp_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      ir          <= NOP;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        pc       <= target;
        resp_pc  <= target;
        discard  <= out_next;
        ir       <= NOP;
        ir_valid <= 1'b0;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (keep)   resp_pc <= resp_pc + 32'd4;
        if (drop)   discard <= discard - 1'b1;
        if (!stall) begin
          if (pop) begin
            ir       <= fifo_head.instr;
            ir_pc    <= fifo_head.pc;
            ir_valid <= 1'b1;
          end else if (bypass) begin
            ir       <= imem_rdata;
            ir_pc    <= resp_pc;
            ir_valid <= 1'b1;
          end else begin
            ir       <= NOP;
            ir_valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios followed by a randomized run, all checked against a
// stream-level model (the address sequence fetch must request and the pc/instruction
// sequence decode must receive), with an in-order variable-latency imem model.
module tb_fetch;

  localparam logic [31:0] NOP_W = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ir, ir_pc;
  logic        ir_valid;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // imem model: in-order responses, each due a random number of cycles after acceptance
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc       = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;

  // stream model
  logic [31:0] exp_req;     // next address fetch must request
  logic [31:0] exp_out;     // next pc decode must be handed
  int          inflight;    // accepted requests not yet answered
  bit          m_halt;
  bit          saw_wrap;
  bit          any_acc;
  logic [31:0] last_acc;
  logic        last_req;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge; stall/redirect/redirect_pc set by caller.
  task automatic step();
    logic        acc, rsp, st, rd;
    logic [31:0] tgt, p_ir, p_pc;
    logic        p_v;
    rsp = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      rsp         = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = memword(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    imem_ready = ($urandom_range(99) < ready_pct);
    #1;
    last_req = imem_req;
    acc = imem_req && imem_ready;
    if (redirect) chk("req_during_redirect", imem_req, 0);
    if (m_halt)   chk("req_while_halted", imem_req, 0);
    if (acc) begin
      chk("req_addr", imem_addr, exp_req);
      if (any_acc && last_acc == 32'hFFFF_FFFC && imem_addr == 32'h0) saw_wrap = 1;
      last_acc = imem_addr;
      any_acc  = 1;
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      exp_req  = exp_req + 32'd4;
      inflight++;
    end
    if (rsp) inflight--;
    chk("inflight_cap", 32'(inflight <= DEPTH), 1);
`ifdef FETCH_MISALIGN_EN
    tgt = redirect_pc;
`else
    tgt = redirect_pc & 32'hFFFF_FFFC;
`endif
    st = stall;
    rd = redirect;
    p_ir = ir;
    p_pc = ir_pc;
    p_v  = ir_valid;
    if (rd) begin
      exp_req = tgt;
      m_halt  = (tgt[1:0] != 2'b00);
    end
    @(negedge clk);
    cyc++;
`ifdef FETCH_MISALIGN_EN
    chk("misaligned_pulse", fetch_misaligned, 32'(rd && (tgt[1:0] != 2'b00)));
`endif
    if (rd) begin
      chk("redirect_valid", ir_valid, 0);
      chk("redirect_ir", ir, NOP_W);
      exp_out = tgt;
    end else if (st) begin
      chk("stall_ir", ir, p_ir);
      chk("stall_pc", ir_pc, p_pc);
      chk("stall_valid", ir_valid, p_v);
    end else if (ir_valid) begin
      chk("ir_pc", ir_pc, exp_out);
      chk("ir", ir, memword(exp_out));
      exp_out = exp_out + 32'd4;
    end else begin
      chk("bubble_ir", ir, NOP_W);
    end
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    q_addr.delete(); q_due.delete();
    inflight = 0; m_halt = 0; any_acc = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_ir", ir, NOP_W);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_valid", ir_valid, 0);
    exp_req = 32'h0;
    exp_out = 32'h0;
    reset = 0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect = 1; redirect_pc = a;
    step();
    redirect = 0;
  endtask

  task automatic wait_first(input string tag, input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      step();
      if (ir_valid) break;
    end
    chk({tag, "_valid"}, ir_valid, 1);
    chk({tag, "_pc"}, ir_pc, a);
  endtask

  // No new requests; everything requested and kept must reach decode.
  task automatic drain(input string tag);
    stall = 0; redirect = 0; ready_pct = 0;
    repeat (12) step();
    chk(tag, exp_out, exp_req);
    chk({tag, "_empty"}, 32'(inflight), 0);
    ready_pct = 100;
  endtask

  initial begin
    do_reset();

    // Streaming, 1-cycle latency
    ready_pct = 100; lat_min = 1; lat_max = 1;
    step();
    chk("t1_valid_cycle2", ir_valid, 0);
    step();
    chk("t1_valid_cycle3", ir_valid, 1);
    chk("t1_first_pc", ir_pc, 32'h0);
    repeat (8) step();

    // Stall held 5 cycles
    stall = 1;
    repeat (5) step();
    chk("t2_req_dropped", last_req, 0);
    stall = 0;
    repeat (10) step();
    drain("t2_no_loss");

    // Redirect with 2 in flight, latency 3
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && inflight < 2; i++) step();
    chk("t3_two_inflight", 32'(inflight), 2);
    redirect_to(32'h100);
    wait_first("t3_first", 32'h100);
    repeat (6) step();

    // Redirect mid-stream at latency 3, then back-to-back redirects
    redirect_to(32'h400);
    wait_first("t4_first", 32'h400);
    step();
    redirect = 1; redirect_pc = 32'h500; step();
    redirect_pc = 32'h600; step();
    redirect = 0;
    wait_first("t4_b2b", 32'h600);
    drain("t4_no_loss");

    // PC wrap
    lat_min = 1; lat_max = 1; saw_wrap = 0;
    redirect_to(32'hFFFF_FFF8);
    repeat (8) step();
    chk("t5_wrap", 32'(saw_wrap), 1);
    drain("t5_no_loss");

    // Misaligned redirect target
    redirect_to(32'h102);
`ifdef FETCH_MISALIGN_EN
    repeat (5) step();
    chk("t6_halted_req", last_req, 0);
    redirect_to(32'h200);
    wait_first("t6_resume", 32'h200);
`else
    wait_first("t6_aligned", 32'h100);
`endif
    drain("t6_no_loss");

    // Randomized traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      ready_pct = 70;
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 3) begin
        redirect = 1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      end else begin
        redirect = 0;
      end
      step();
    end
    drain("rand_no_loss");

    // Reset in the middle of traffic
    ready_pct = 100;
    repeat (3) step();
    do_reset();
    wait_first("rst_mid_first", 32'h0);
    repeat (10) step();
    drain("rst_mid_no_loss");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
